// File: rtl/fpnew_pipe_elastic.sv
// fpnew_pipe_elastic: elastic pipeline shift register with valid/ready handshake,
// bubble collapsing, selective squash by tag, occupancy and busy status.
// Optional feature macro: FPNEW_PIPE_STALL_CNT_EN adds a saturating counter of
// output stall cycles on stall_cnt_o; without it stall_cnt_o is tied to 0.
module fpnew_pipe_elastic #(
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned TagWidth    = 4,
   parameter int unsigned NumPipeRegs = 2,
   parameter int unsigned CntWidth    = 16,
   localparam int unsigned OccWidth   = (NumPipeRegs > 0) ? $clog2(NumPipeRegs + 1) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DataWidth-1:0] data_i,
   input  logic [TagWidth-1:0]  tag_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 flush_i,
   input  logic                 kill_i,
   input  logic [TagWidth-1:0]  kill_tag_i,
   output logic [DataWidth-1:0] data_o,
   output logic [TagWidth-1:0]  tag_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [OccWidth-1:0]  occupancy_o,
   output logic                 busy_o,
   output logic [CntWidth-1:0]  stall_cnt_o
);

   // Register array is at least one entry wide so the 0-stage build still elaborates.
   localparam int unsigned QW = (NumPipeRegs > 0) ? NumPipeRegs : 1;

   // Stage view: index 0 is the input, index i+1 is register i.
   logic [NumPipeRegs:0]                valid_d;
   logic [NumPipeRegs:0][DataWidth-1:0] data_d;
   logic [NumPipeRegs:0][TagWidth-1:0]  tag_d;
   logic [NumPipeRegs:0]                killm;
   logic [NumPipeRegs:0]                stage_ready;

   logic [QW-1:0]                valid_q;
   logic [QW-1:0][DataWidth-1:0] data_q;
   logic [QW-1:0][TagWidth-1:0]  tag_q;

   // Assemble the per-stage entries from the input and the registers.
   always_comb begin
      valid_d[0] = in_valid_i;
      data_d[0]  = data_i;
      tag_d[0]   = tag_i;
      for (int i = 0; i < int'(NumPipeRegs); i++) begin
         valid_d[i+1] = valid_q[i];
         data_d[i+1]  = data_q[i];
         tag_d[i+1]   = tag_q[i];
      end
   end

   // Squash match on every stage, including the input and the output entry.
   always_comb begin
      for (int i = 0; i <= int'(NumPipeRegs); i++)
         killm[i] = kill_i & valid_d[i] & (tag_d[i] == kill_tag_i);
   end

   // Ready ripples back from the output; empty or squashed stages never block.
   always_comb begin
      logic rdy;
      rdy = out_ready_i | killm[NumPipeRegs];
      stage_ready[NumPipeRegs] = rdy;
      for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
         rdy = rdy | ~valid_q[i] | killm[i+1];
         stage_ready[i] = rdy;
      end
   end

   assign in_ready_o  = stage_ready[0] | killm[0];
   assign out_valid_o = valid_d[NumPipeRegs] & ~killm[NumPipeRegs];
   assign data_o      = data_d[NumPipeRegs];
   assign tag_o       = tag_d[NumPipeRegs];
   assign busy_o      = |valid_d;

   generate
      if (NumPipeRegs > 0) begin : g_regs
         // Stage registers: flush beats advance, which beats hold; a squashed
         // entry is dropped at its destination rather than handed off.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               valid_q <= '0;
               data_q  <= '0;
               tag_q   <= '0;
            end else begin
               for (int i = 0; i < int'(NumPipeRegs); i++) begin
                  if (flush_i)
                     valid_q[i] <= 1'b0;
                  else if (stage_ready[i])
                     valid_q[i] <= valid_d[i] & ~killm[i];
                  else
                     valid_q[i] <= valid_q[i] & ~killm[i+1];
                  // Payload only moves with a valid entry so it can be clock-gated.
                  if (stage_ready[i] & valid_d[i]) begin
                     data_q[i] <= data_d[i];
                     tag_q[i]  <= tag_d[i];
                  end
               end
            end
         end
      end else begin : g_noregs
         assign valid_q = '0;
         assign data_q  = '0;
         assign tag_q   = '0;
      end
   endgenerate

   // Occupancy is the count of valid registered stages.
   always_comb begin
      occupancy_o = '0;
      for (int i = 0; i < int'(NumPipeRegs); i++)
         occupancy_o = occupancy_o + OccWidth'(valid_q[i]);
   end

`ifdef FPNEW_PIPE_STALL_CNT_EN
   logic [CntWidth-1:0] stall_cnt_q;

   // Count cycles where a valid output is held back; saturate, clear on flush.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         stall_cnt_q <= '0;
      else if (flush_i)
         stall_cnt_q <= '0;
      else if (out_valid_o & ~out_ready_i & ~(&stall_cnt_q))
         stall_cnt_q <= stall_cnt_q + 1'b1;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule
